matrix_key_scanner: RTL and testbench
=====================================

MATRIX_KEY_SCANNER -- requirements
Module: matrix_key_scanner

Interface
REQ-001 Parameter SCAN_DIVIDER, default 1000: clocks each column is driven (dwell); legal range 2..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical samples needed to accept a key change; legal range 1..7.
REQ-003 Port clock  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port scan_enable  input  1  high = scanning runs; low = scan frozen.
REQ-006 Port row_in  input  7  row sense lines; 1 = key closed; synchronized externally.
REQ-007 Port ring_counter  output  5  one-hot column drive: 00001 = column 4 … 10000 = column 0.
REQ-008 Port key_valid  output  1  event held in output register.
REQ-009 Port key_ready  input  1  consumer accepts the event when key_valid && key_ready on a rising edge.
REQ-010 Port key_code  output  6  {column index[5:3], row index[2:0]}; column 0..4, row 0..6.
REQ-011 Port key_pressed  output  1  1 = press event, 0 = release event.

Function
REQ-012 Column order SHALL be 00001 → 00010 → 00100 → 01000 → 10000 → 00001 (column 4 down to 0, then wrap).
REQ-013 Dwell counter SHALL count 0..SCAN_DIVIDER-1; row_in is sampled only at count SCAN_DIVIDER-1 (settled end of dwell).
REQ-014 Each of the 35 keys SHALL hold a debounced state (reset = released) and a sample-agreement counter.
REQ-015 At a sample, a key whose raw value differs from its debounced state SHALL increment its counter; an equal value clears it to 0.
REQ-016 A key SHALL become a change candidate when its counter reaches DEBOUNCE_SCANS.
REQ-017 At most one event per sample point: the lowest-index candidate row of the current column is selected.
REQ-018 If the output register is empty, or is being emptied by a handshake in that same cycle, the selected event SHALL load and the key's debounced state flip, with its counter cleared, in the same cycle.
REQ-019 key_valid SHALL rise the cycle after the sample clock (latency 1); key_code and key_pressed SHALL remain stable while key_valid is high.
REQ-020 The column SHALL advance only after a sample with no remaining candidates in that column; otherwise the same column dwells again.
REQ-021 If the output register is full and not being emptied at a sample, nothing commits and the column dwells again (no event lost).
REQ-022 Other candidate rows in a held column keep their counters saturated at DEBOUNCE_SCANS until reported.
REQ-023 scan_enable low: ring_counter = 00000; dwell, debounce and column state frozen; output handshake still operates.
REQ-024 scan_enable rising: scanning resumes at the held column with the dwell counter restarted at 0.
REQ-025 An illegal ring state (not one-hot) SHALL recover to 00001 on the next clock.

Reset
REQ-026 reset asserted SHALL immediately force ring_counter = 00001, dwell count 0, all keys released, all counters 0, key_valid = 0, key_code = 000000, key_pressed = 0.
REQ-027 Reset mid-dwell or with an event pending SHALL discard all in-flight state; no event is produced for it.

Configuration
REQ-028 Macro MATRIX_KEY_DEBOUNCE_EN defined: debounce per REQ-014..REQ-016.
REQ-029 Macro undefined: counters absent; any differing sample is immediately a candidate, equivalent to DEBOUNCE_SCANS = 1; DEBOUNCE_SCANS is ignored.

Structure
REQ-030 Shared package matrix_pkg SHALL hold NUM_COLS = 5, NUM_ROWS = 7, the one-hot column constants COUNT4..COUNT0, and the key-code typedef.
REQ-031 Sub-module matrix_key_debouncer SHALL implement one key's state and counter; it is instantiated 35 times.

Verification (bench: SCAN_DIVIDER = 4, DEBOUNCE_SCANS = 2, key_ready = 1 unless stated)
REQ-032 Reset, then scan for 20 clocks, no keys -> ring_counter 00001, 00010, 00100, 01000, 10000 every 4 clocks, then wraps; key_valid stays 0.
REQ-033 Hold row 3 high during column 2 for 2 full scans -> one event, key_code = 010011, key_pressed = 1; on release, after 2 scans -> same code with key_pressed = 0.
REQ-034 Row 1 high for a single column-4 sample only -> no event; with the macro undefined -> event 100001 press.
REQ-035 Rows 0 and 5 of column 1 pressed with key_ready = 0 -> 001000 held stable, column stays 01000; raise key_ready -> 001101 follows, then the column advances.
REQ-036 Assert reset while key_valid = 1 -> key_valid = 0 and ring_counter = 00001 before the next clock edge; no stale event after release.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, key-code type and ring helpers for the 5x7 matrix key scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; consumers are matrix_key_scanner and matrix_key_debouncer.
package matrix_pkg;

   localparam int NUM_COLS = 5;
   localparam int NUM_ROWS = 7;

   // One-hot column drive patterns; column 4 is the first column after reset
   localparam logic [4:0] COUNT4 = 5'b00001;
   localparam logic [4:0] COUNT3 = 5'b00010;
   localparam logic [4:0] COUNT2 = 5'b00100;
   localparam logic [4:0] COUNT1 = 5'b01000;
   localparam logic [4:0] COUNT0 = 5'b10000;

   typedef struct packed {
      logic [2:0] col;
      logic [2:0] row;
   } key_code_t;

   function automatic logic is_onehot5(input logic [4:0] v);
      return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
   endfunction

   function automatic logic [2:0] ring_to_col(input logic [4:0] v);
      logic [2:0] col;
      case (v)
         COUNT4:  col = 3'd4;
         COUNT3:  col = 3'd3;
         COUNT2:  col = 3'd2;
         COUNT1:  col = 3'd1;
         COUNT0:  col = 3'd0;
         default: col = 3'd0;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/matrix_key_debouncer.sv
// One key: debounced state plus sample-agreement counter (counter only with MATRIX_KEY_DEBOUNCE_EN).
// Latency: candidate flag is combinational at the sample; state/counter update on that clock edge.
// Backpressure: a candidate not committed keeps its counter saturated until the scanner commits it.
module matrix_key_debouncer
   import matrix_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_sample,
   input  logic i_raw,
   input  logic i_commit,
   output logic o_candidate
);

   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 7) begin : g_bad_debounce
      $error("matrix_key_debouncer: DEBOUNCE_SCANS must be 1..7");
   end

   logic r_state;
   logic w_differ;

   assign w_differ = i_raw ^ r_state;

`ifdef MATRIX_KEY_DEBOUNCE_EN
   localparam logic [2:0] DEB = 3'(DEBOUNCE_SCANS);

   logic [2:0] r_count;
   logic [2:0] w_count_next;

   // Agreement count: climbs while the raw sample differs, saturates at DEB, clears on agreement
   always_comb begin
      w_count_next = r_count;
      if (i_sample) begin
         if (!w_differ) begin
            w_count_next = 3'd0;
         end else if (r_count < DEB) begin
            w_count_next = r_count + 3'd1;
         end
      end
   end

   assign o_candidate = i_sample && w_differ && (w_count_next == DEB);

   // Counter register; a committed change restarts the count
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= 3'd0;
      end else if (i_commit) begin
         r_count <= 3'd0;
      end else begin
         r_count <= w_count_next;
      end
   end
`else
   // Without debounce any differing sample is a change candidate at once
   assign o_candidate = i_sample && w_differ;
`endif

   // Debounced state flips only when the scanner accepts this key's event
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= 1'b0;
      end else if (i_commit) begin
         r_state <= ~r_state;
      end
   end

endmodule

// File: rtl/matrix_key_scanner.sv
// 5x7 key matrix scanner: one-hot column drive, per-key debounce (MATRIX_KEY_DEBOUNCE_EN), one event register.
// Latency: key_valid rises the cycle after the dwell-end sample that produced the event.
// Backpressure: key_valid/key_ready; a full register holds the column, candidates wait saturated, none lost.
module matrix_key_scanner
   import matrix_pkg::*;
#(
   parameter int SCAN_DIVIDER   = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scan_enable,
   input  logic [6:0] row_in,
   output logic [4:0] ring_counter,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [5:0] key_code,
   output logic       key_pressed
);

   if (SCAN_DIVIDER < 2 || SCAN_DIVIDER > 65535) begin : g_bad_divider
      $error("matrix_key_scanner: SCAN_DIVIDER must be 2..65535");
   end

   localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIVIDER - 1);

   logic [4:0]                   r_ring;
   logic [15:0]                  r_dwell;
   logic                         r_valid;
   key_code_t                    r_code;
   logic                         r_pressed;

   logic                         w_ring_ok;
   logic                         w_sample;
   logic                         w_room;
   logic                         w_any;
   logic                         w_commit;
   logic                         w_advance;
   logic [2:0]                   w_sel_row;
   logic [NUM_COLS-1:0]          w_col_sel;
   logic [NUM_COLS*NUM_ROWS-1:0] w_cand;
   logic [NUM_ROWS-1:0]          w_cand_row;
   logic [NUM_ROWS-1:0]          w_commit_row;
   logic [NUM_ROWS-1:0]          w_remaining;

   assign w_ring_ok = is_onehot5(r_ring);
   assign w_sample  = scan_enable && w_ring_ok && (r_dwell == DWELL_LAST);

   // Column c is driven by ring bit (NUM_COLS-1-c); each key sees only its own column's samples
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      assign w_col_sel[c] = r_ring[NUM_COLS-1-c];
      for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
         matrix_key_debouncer #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_key (
            .i_clock     (clock),
            .i_reset     (reset),
            .i_sample    (w_sample && w_col_sel[c]),
            .i_raw       (row_in[r]),
            .i_commit    (w_commit_row[r] && w_col_sel[c]),
            .o_candidate (w_cand[c*NUM_ROWS + r])
         );
      end
   end

   // Fold the active column's candidates onto rows and pick the lowest-index one
   always_comb begin
      w_cand_row = '0;
      w_sel_row  = 3'd0;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            w_cand_row[r] = w_cand_row[r] | w_cand[c*NUM_ROWS + r];
         end
      end
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (w_cand_row[r]) begin
            w_sel_row = 3'(r);
         end
      end
   end

   assign w_any        = |w_cand_row;
   assign w_room       = !r_valid || key_ready;
   assign w_commit     = w_any && w_room;
   assign w_commit_row = w_commit ? (7'd1 << w_sel_row) : 7'd0;
   assign w_remaining  = w_cand_row & ~w_commit_row;
   assign w_advance    = w_sample && (w_remaining == 7'd0);

   // Column ring and dwell counter; dwell is held at 0 while disabled so a resume restarts it
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ring  <= COUNT4;
         r_dwell <= 16'd0;
      end else if (!w_ring_ok) begin
         r_ring  <= COUNT4;
         r_dwell <= 16'd0;
      end else if (!scan_enable) begin
         r_dwell <= 16'd0;
      end else if (w_sample) begin
         r_dwell <= 16'd0;
         if (w_advance) begin
            r_ring <= {r_ring[3:0], r_ring[4]};
         end
      end else begin
         r_dwell <= r_dwell + 16'd1;
      end
   end

   // Event register: load on commit, otherwise drain on handshake; contents stable while valid
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_code    <= '0;
         r_pressed <= 1'b0;
      end else if (w_commit) begin
         r_valid    <= 1'b1;
         r_code.col <= ring_to_col(r_ring);
         r_code.row <= w_sel_row;
         r_pressed  <= row_in[w_sel_row];
      end else if (r_valid && key_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign ring_counter = scan_enable ? r_ring : 5'b00000;
   assign key_valid    = r_valid;
   assign key_code     = r_code;
   assign key_pressed  = r_pressed;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Self-checking bench for matrix_key_scanner against a behavioural key-matrix model.
// Latency: checks every clock, 1 ns after the rising edge.
// Backpressure: key_ready is driven low/high/random to exercise held columns.
module tb_matrix_key_scanner;

   localparam int DIV   = 4;
   localparam int DEB_P = 2;
`ifdef MATRIX_KEY_DEBOUNCE_EN
   localparam int DEB = DEB_P;
`else
   localparam int DEB = 1;
`endif
   localparam int EXP_SINGLE = (DEB == 1) ? 2 : 0;

   logic       clock = 1'b0;
   logic       reset;
   logic       scan_enable;
   logic [6:0] row_in;
   logic [4:0] ring_counter;
   logic       key_valid;
   logic       key_ready;
   logic [5:0] key_code;
   logic       key_pressed;

   bit phys [0:4][0:6];

   int tests = 0;
   int fails = 0;

   int         m_col;
   int         m_dwell;
   bit         m_state [0:34];
   int         m_cnt   [0:34];
   bit         m_valid;
   logic [5:0] m_code;
   bit         m_pressed;

   logic [6:0] ev_q [$];

   matrix_key_scanner #(
      .SCAN_DIVIDER   (DIV),
      .DEBOUNCE_SCANS (DEB_P)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .scan_enable  (scan_enable),
      .row_in       (row_in),
      .ring_counter (ring_counter),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .key_code     (key_code),
      .key_pressed  (key_pressed)
   );

   always #5 clock = ~clock;

   always_comb begin
      row_in = 7'd0;
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 7; r++)
            if (ring_counter[4-c] && phys[c][r]) row_in[r] = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_col = 4; m_dwell = 0; m_valid = 0; m_code = 6'd0; m_pressed = 0;
      for (int k = 0; k < 35; k++) begin
         m_state[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic model_edge(input bit en, input bit rdy);
      bit room;
      int first;
      int rem;
      int k;
      room = !m_valid || rdy;
      if (m_valid && rdy) m_valid = 0;
      if (!en) begin
         m_dwell = 0;
      end else if (m_dwell < DIV - 1) begin
         m_dwell++;
      end else begin
         m_dwell = 0; first = -1; rem = 0;
         for (int r = 0; r < 7; r++) begin
            k = m_col * 7 + r;
            if (phys[m_col][r] != m_state[k]) m_cnt[k] = (m_cnt[k] < DEB) ? m_cnt[k] + 1 : DEB;
            else m_cnt[k] = 0;
            if (m_cnt[k] == DEB) begin
               if (first < 0) first = r;
               else rem++;
            end
         end
         if (first >= 0) begin
            if (room) begin
               k = m_col * 7 + first;
               m_state[k] = !m_state[k];
               m_cnt[k]   = 0;
               m_valid    = 1;
               m_code     = {3'(m_col), 3'(first)};
               m_pressed  = m_state[k];
            end else begin
               rem++;
            end
         end
         if (rem == 0) m_col = (m_col == 0) ? 4 : m_col - 1;
      end
   endtask

   task automatic step(input bit en, input bit rdy);
      scan_enable = en;
      key_ready   = rdy;
      @(negedge clock);
      if (key_valid && key_ready) ev_q.push_back({key_pressed, key_code});
      model_edge(en, rdy);
      @(posedge clock);
      #1;
      check("ring", ring_counter, en ? (32'd1 << (4 - m_col)) : 32'd0);
      check("valid", key_valid, m_valid);
      if (m_valid) begin
         check("code", key_code, m_code);
         check("pressed", key_pressed, m_pressed);
      end
   endtask

   task automatic wait_event(input string tag, input int budget);
      for (int i = 0; i < budget && ev_q.size() == 0; i++) step(1, 1);
      check(tag, ev_q.size() > 0, 1);
   endtask

   initial begin
      reset = 1'b1; scan_enable = 1'b1; key_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_ring", ring_counter, 5'b00001);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 6'b000000);
      check("rst_pressed", key_pressed, 1'b0);
      reset = 1'b0;

      // Idle scan: column moves every DIV clocks and wraps
      for (int i = 1; i <= 20; i++) begin
         step(1, 1);
         check("idle_ring", ring_counter, 32'd1 << ((i / 4) % 5));
         check("idle_valid", key_valid, 1'b0);
      end

      // Press and release column 2 row 3
      ev_q.delete();
      phys[2][3] = 1;
      wait_event("press_wait", 100);
      check("press_ev", ev_q.pop_front(), {1'b1, 6'b010011});
      phys[2][3] = 0;
      wait_event("release_wait", 100);
      check("release_ev", ev_q.pop_front(), {1'b0, 6'b010011});

      // Glitch visible to a single column-4 sample only
      for (int i = 0; i < 40 && !(m_col == 4 && m_dwell == 0); i++) step(1, 1);
      ev_q.delete();
      phys[4][1] = 1;
      repeat (DIV) step(1, 1);
      phys[4][1] = 0;
      repeat (60) step(1, 1);
      check("glitch_count", ev_q.size(), EXP_SINGLE);
      if (ev_q.size() > 0) check("glitch_ev", ev_q[0], {1'b1, 6'b100001});

      // Two keys in column 1 with the consumer stalled
      ev_q.delete();
      phys[1][0] = 1; phys[1][5] = 1;
      repeat (60) step(1, 0);
      check("stall_valid", key_valid, 1'b1);
      check("stall_code", key_code, 6'b001000);
      check("stall_pressed", key_pressed, 1'b1);
      check("stall_ring", ring_counter, 5'b01000);
      repeat (30) step(1, 1);
      check("stall_count", ev_q.size() >= 2, 1);
      if (ev_q.size() >= 2) begin
         check("stall_ev0", ev_q[0], {1'b1, 6'b001000});
         check("stall_ev1", ev_q[1], {1'b1, 6'b001101});
      end
      phys[1][0] = 0; phys[1][5] = 0;
      repeat (80) step(1, 1);

      // Scan disabled: drive off, handshake still drains
      repeat (10) step(0, 1);
      check("disabled_ring", ring_counter, 5'b00000);
      repeat (12) step(1, 1);

      // Randomised keys, backpressure and enable
      begin
         bit en = 1;
         int c;
         int r;
         for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
               c = $urandom_range(0, 4); r = $urandom_range(0, 6);
               phys[c][r] = !phys[c][r];
            end
            if ($urandom_range(0, 99) == 0) en = !en;
            step(en, $urandom_range(0, 3) != 0);
         end
      end

      // Reset with an event pending
      ev_q.delete();
      phys[3][6] = !phys[3][6];
      for (int i = 0; i < 200 && !m_valid; i++) step(1, 0);
      check("pre_reset_valid", key_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("async_valid", key_valid, 1'b0);
      check("async_ring", ring_counter, 5'b00001);
      for (int c = 0; c < 5; c++)
         for (int r = 0; r < 7; r++) phys[c][r] = 0;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      ev_q.delete();
      repeat (60) step(1, 1);
      check("no_stale_events", ev_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
